// File: rtl/rec2pol_seq_if.sv
// Bundle between rec2pol_seq, its upstream/downstream and the CORDIC core.
// master drives samples, core results and out_ready; slave is the sequencer.
interface rec2pol_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        cor_enable;
    logic        cor_start;
    logic [31:0] cor_x;
    logic [31:0] cor_y;
    logic [31:0] cor_mod;
    logic [31:0] cor_angle;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_mod;
    logic [31:0] out_angle;
    logic        out_flip;
    logic        busy;

    modport master (
        output in_valid, in_x, in_y, cor_mod, cor_angle, out_ready,
        input  in_ready, cor_enable, cor_start, cor_x, cor_y,
        input  out_valid, out_mod, out_angle, out_flip, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, cor_mod, cor_angle, out_ready,
        output in_ready, cor_enable, cor_start, cor_x, cor_y,
        output out_valid, out_mod, out_angle, out_flip, busy
    );
endinterface

// File: rtl/rec2pol_seq.sv
// Sequencer in front of the rec2pol CORDIC vectoring core; one sample in flight.
// Optional QUAD_FOLD_EN: fold x<0 samples into the right half-plane, flag +180 deg.
module rec2pol_seq #(
    parameter int NITER = 32
) (
    input  logic          clock,
    input  logic          reset,
    rec2pol_seq_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_ITER    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [5:0] LAST = 6'(NITER - 1);

    logic [2:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] cx_q, cx_d;
    logic [31:0] cy_q, cy_d;
    logic [31:0] mod_q, mod_d;
    logic [31:0] ang_q, ang_d;
    logic        fold_q, fold_d;
    logic        flip_q, flip_d;

    logic [31:0] fx;
    logic [31:0] fy;
    logic        fneg;

`ifdef QUAD_FOLD_EN
    // -(-2^31) has no 32-bit representation, clamp to the largest positive
    function automatic logic [31:0] sat_neg(input logic [31:0] v);
        if (v == 32'h8000_0000) begin
            return 32'h7FFF_FFFF;
        end
        return (~v) + 32'd1;
    endfunction

    // left half-plane samples are mirrored through the origin
    always_comb begin
        fneg = bus.in_x[31];
        fx   = fneg ? sat_neg(bus.in_x) : bus.in_x;
        fy   = fneg ? sat_neg(bus.in_y) : bus.in_y;
    end
`else
    // no folding: raw samples go to the core
    always_comb begin
        fneg = 1'b0;
        fx   = bus.in_x;
        fy   = bus.in_y;
    end
`endif

    // next-state and datapath updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        mod_d   = mod_q;
        ang_d   = ang_q;
        fold_d  = fold_q;
        flip_d  = flip_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    cx_d    = fx;
                    cy_d    = fy;
                    fold_d  = fneg;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = 6'd0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (cnt_q == LAST) begin
                    cnt_d   = 6'd0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_CAPTURE: begin
                mod_d   = bus.cor_mod;
                ang_d   = bus.cor_angle;
                flip_d  = fold_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            cx_q    <= 32'd0;
            cy_q    <= 32'd0;
            mod_q   <= 32'd0;
            ang_q   <= 32'd0;
            fold_q  <= 1'b0;
            flip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            mod_q   <= mod_d;
            ang_q   <= ang_d;
            fold_q  <= fold_d;
            flip_q  <= flip_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.cor_start  = (state_q == S_START);
    assign bus.cor_enable = (state_q == S_START) || (state_q == S_ITER);
    assign bus.cor_x      = cx_q;
    assign bus.cor_y      = cy_q;
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_mod    = mod_q;
    assign bus.out_angle  = ang_q;
    assign bus.out_flip   = flip_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_rec2pol_seq.sv
// Bench for rec2pol_seq with a stand-in core whose outputs encode operands
// and enabled-cycle count; results are checked through a scoreboard queue.
module tb_rec2pol_seq;
    localparam int NITER = 32;
`ifdef QUAD_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    typedef struct {
        logic [31:0] m;
        logic [31:0] a;
        logic        f;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rec2pol_seq_if bus();

    rec2pol_seq #(.NITER(NITER)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // stand-in core: loads on start, counts enabled iteration cycles
    logic [31:0] lx = 32'd0;
    logic [31:0] ly = 32'd0;
    logic [5:0]  ccnt = 6'd0;
    always @(posedge clock) begin
        if (bus.cor_enable && bus.cor_start) begin
            lx   <= bus.cor_x;
            ly   <= bus.cor_y;
            ccnt <= 6'd0;
        end else if (bus.cor_enable) begin
            ccnt <= ccnt + 6'd1;
        end
    end
    assign bus.cor_mod   = lx + ly + {26'd0, ccnt};
    assign bus.cor_angle = (lx ^ 32'h5A5A_0000) - ly + {26'd0, ccnt} * 32'd3;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int n_out = 0;
    res_t sb[$];
    int unsigned acc_cyc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] neg_sat(input logic [31:0] v);
        if (v == 32'h8000_0000) return 32'h7FFF_FFFF;
        return 32'd0 - v;
    endfunction

    function automatic logic [31:0] fold_x(input logic [31:0] x);
        return (FOLD && x[31]) ? neg_sat(x) : x;
    endfunction

    function automatic logic [31:0] fold_y(input logic [31:0] x,
                                           input logic [31:0] y);
        return (FOLD && x[31]) ? neg_sat(y) : y;
    endfunction

    // result monitor: compare on every output handshake
    always @(negedge clock) begin
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                res_t r;
                r = sb.pop_front();
                check("out_mod", bus.out_mod, r.m);
                check("out_angle", bus.out_angle, r.a);
                check("out_flip", {31'd0, bus.out_flip}, {31'd0, r.f});
                n_out++;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // offer a sample and wait for its accept edge; returns at edge+1
    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input bit keep);
        bit ok;
        res_t r;
        logic [31:0] fx;
        logic [31:0] fy;
        bus.in_valid = 1'b1;
        bus.in_x = x;
        bus.in_y = y;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        fx = fold_x(x);
        fy = fold_y(x, y);
        r.m = fx + fy + 32'(NITER);
        r.a = (fx ^ 32'h5A5A_0000) - fy + 32'(NITER * 3);
        r.f = FOLD && x[31];
        sb.push_back(r);
        #1;
        acc_cyc = cyc;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    // wait for out_valid, return cycles since last accept; ends at a negedge
    task automatic wait_out(output int lat);
        bit ok;
        ok = 1'b0;
        lat = -1;
        for (int i = 0; i < NITER + 40; i++) begin
            @(negedge clock);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("out_timeout", 32'd0, 32'd1);
        end else begin
            lat = int'(cyc - acc_cyc);
        end
    endtask

    int lat;
    int unsigned b_cyc;
    int unsigned prev_acc;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_x = 32'd0;
        bus.in_y = 32'd0;
        bus.out_ready = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_cor_en", {31'd0, bus.cor_enable}, 32'd0);
        check("rst_cor_start", {31'd0, bus.cor_start}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_cor_x", bus.cor_x, 32'd0);
        check("rst_out_mod", bus.out_mod, 32'd0);
        step();
        reset = 1'b1;
        step();

        // T1: basic sample, latency and START outputs
        send(32'h0001_0000, 32'd0, 1'b0);
        @(negedge clock);
        check("t1_start", {31'd0, bus.cor_start}, 32'd1);
        check("t1_enable", {31'd0, bus.cor_enable}, 32'd1);
        check("t1_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("t1_cor_x", bus.cor_x, 32'h0001_0000);
        @(negedge clock);
        check("t1_iter_start", {31'd0, bus.cor_start}, 32'd0);
        check("t1_iter_en", {31'd0, bus.cor_enable}, 32'd1);
        wait_out(lat);
        check("t1_latency", 32'(lat), 32'(NITER + 2));
        @(negedge clock);
        check("t1_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        check("t1_idle_ready", {31'd0, bus.in_ready}, 32'd1);
        step();

        // T2/T3: result held with out_ready low, no accept meanwhile
        bus.out_ready = 1'b0;
        send(32'h0001_0000, 32'h0001_0000, 1'b0);
        wait_out(lat);
        check("t2_latency", 32'(lat), 32'(NITER + 2));
        step();
        bus.in_valid = 1'b1;
        bus.in_x = 32'h0003_0000;
        bus.in_y = 32'hFFFE_0000;
        repeat (10) @(negedge clock);
        check("t3_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t3_hold_mod", bus.out_mod, sb[0].m);
        check("t3_hold_angle", bus.out_angle, sb[0].a);
        check("t3_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("t3_cor_x", bus.cor_x, 32'h0001_0000);
        step();
        bus.out_ready = 1'b1;
        b_cyc = cyc;
        send(32'h0003_0000, 32'hFFFE_0000, 1'b0);
        check("t3_accept_gap", 32'(acc_cyc - b_cyc), 32'd2);
        wait_out(lat);
        step();

        // T4: reset in the middle of ITER drops the sample
        send(32'h0002_0000, 32'h0001_0000, 1'b0);
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b0;
        step();
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        check("t4_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t4_cor_en", {31'd0, bus.cor_enable}, 32'd0);
        check("t4_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t4_busy", {31'd0, bus.busy}, 32'd0);
        step();
        send(32'h0001_0000, 32'd0, 1'b0);
        wait_out(lat);
        check("t4_latency", 32'(lat), 32'(NITER + 2));
        step();

        // T5: back-to-back samples with in_valid held high
        for (int i = 0; i < 4; i++) begin
            send(32'h0000_1000 * (i + 1), 32'h0123_0000 + 32'(i), 1'b1);
            if (i > 0) begin
                check("t5_spacing", 32'(acc_cyc - prev_acc), 32'(NITER + 4));
            end
            prev_acc = acc_cyc;
        end
        bus.in_valid = 1'b0;
        wait_out(lat);
        step();

        // T6: negative x, saturation corner and zero sample
        send(32'hFFFF_0000, 32'd0, 1'b0);
        @(negedge clock);
        check("t6_cor_x", bus.cor_x, FOLD ? 32'h0001_0000 : 32'hFFFF_0000);
        wait_out(lat);
        step();
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        @(negedge clock);
        check("t6_sat_x", bus.cor_x, FOLD ? 32'h7FFF_FFFF : 32'h8000_0000);
        check("t6_sat_y", bus.cor_y, FOLD ? 32'h7FFF_FFFF : 32'h8000_0000);
        wait_out(lat);
        step();
        send(32'd0, 32'd0, 1'b0);
        wait_out(lat);
        step();

        @(negedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("n_results", 32'(n_out), 32'd11);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
